md_unit: RTL

Parametrised multiply/divide unit for the pipelined MIPS core, successor to the fixed-latency HI/LO unit. It sits beside the EX-stage ALU and owns the HI/LO register pair. It adds width and latency parameters, a true bit-serial restoring divider, multiply-accumulate/subtract modes, defined divide-by-zero/overflow results, and a cancel input for exception flush. The stall logic reads `busy`; the forwarding and M-stage read-back paths read `hi`/`lo`.

---
 rtl/md_unit.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/md_unit.sv
// md_unit: multiply/divide unit owning the HI/LO pair.
// Multiplies form the full product at acceptance and commit after MUL_LAT edges.
// Divides run a bit-serial restoring divider (one bit per cycle), then a sign-fix/commit cycle.
module md_unit #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] wd,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] FIX  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         mode_q, mode_d;    // op[2:1]: 00 plain, 10 accumulate, 11 subtract
    logic [2*WIDTH-1:0] prod_q, prod_d;    // product; low half holds raw dividend for b==0
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;      // dividend bits shift out as quotient bits shift in
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               bzero_q, bzero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [2*WIDTH-1:0] ext_a, ext_b, hilo;
    logic [WIDTH:0]     trial;
    logic               is_div, a_neg, b_neg;

    assign busy = (state_q != IDLE);
    assign hi   = hi_q;
    assign lo   = lo_q;

    // Next-state, datapath and HI/LO update with reset > cancel > start > mthi > mtlo priority.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        prod_d  = prod_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        bzero_d = bzero_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        is_div = (op[2:1] == 2'b01);
        a_neg  = op[0] & a[WIDTH-1];
        b_neg  = op[0] & b[WIDTH-1];
        ext_a  = op[0] ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        ext_b  = op[0] ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        hilo   = {hi_q, lo_q};
        // Partial remainder < divisor keeps this within WIDTH+1 bits for non-zero divisors.
        trial  = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};

        if (cancel) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_d = op[2:1];
                        if (is_div) begin
                            state_d = DIV;
                            cnt_d   = CW'(WIDTH - 1);
                            quo_d   = a_neg ? -a : a;
                            dvs_d   = b_neg ? -b : b;
                            rem_d   = '0;
                            qneg_d  = a_neg ^ b_neg;
                            rneg_d  = a_neg;
                            bzero_d = (b == '0);
                            prod_d  = {{WIDTH{1'b0}}, a};
                        end else begin
                            state_d = MUL;
                            cnt_d   = CW'(MUL_LAT - 1);
                            prod_d  = ext_a * ext_b;
                        end
                    end else if (mthi) begin
                        hi_d = wd;
                    end else if (mtlo) begin
                        lo_d = wd;
                    end
                end
                MUL: begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                        case (mode_q)
                            2'b10:   {hi_d, lo_d} = hilo + prod_q;
                            2'b11:   {hi_d, lo_d} = hilo - prod_q;
                            default: {hi_d, lo_d} = prod_q;
                        endcase
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                DIV: begin
                    if (!trial[WIDTH]) begin
                        rem_d = trial[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    if (cnt_q == '0) begin
                        state_d = FIX;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin  // FIX
                    state_d = IDLE;
                    if (bzero_q) begin
                        lo_d = '1;
                        hi_d = prod_q[WIDTH-1:0];
                    end else begin
                        lo_d = qneg_q ? -quo_q : quo_q;
                        hi_d = rneg_q ? -rem_q : rem_q;
                    end
                end
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            bzero_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            bzero_q <= bzero_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule
